tone_note_decoder: RTL

//  Receive-side counterpart of the sine tone player: observes the signed sine sample stream
//  and recovers the 4-bit note code that produced it. Measures the clock-count period between

---
 rtl/tone_note_decoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tone_note_decoder.sv
// Recovers the note code from the signed sine sample stream by timing rising zero
// crossings and mapping the rounded period back through the tone player's limit table.
module tone_note_decoder #(
   parameter int unsigned WIDTH        = 7,
   parameter int unsigned PERIOD_SHIFT = 12,
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned STABLE_N     = 3,
   parameter int unsigned TIMEOUT_Q    = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sample_in,
   output logic [3:0]       note_out,
   output logic             note_valid,
   output logic             locked,
   output logic [CNT_W-1:0] period_out
);

   localparam int unsigned    QW         = CNT_W + 1;
   localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'((TIMEOUT_Q << PERIOD_SHIFT) - 1);
   localparam logic [QW-1:0]  RoundHalf  = QW'(1 << (PERIOD_SHIFT - 1));
   localparam int unsigned    RunW       = $clog2(STABLE_N + 1);
   localparam logic [RunW-1:0] RunMax    = RunW'(STABLE_N);
   localparam logic [3:0]     NoteNone   = 4'hF;
   localparam logic [3:0]     NoteRest   = 4'd11;

   typedef enum logic [1:0] {StIdle, StMeasure, StSilent} state_e;

   state_e           state_q, state_d;
   logic             sign_q;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [3:0]       cand_q, cand_d;
   logic [RunW-1:0]  run_q, run_d;
   logic [3:0]       note_q, note_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;

   logic             xing;
   logic             timeout;
   logic [CNT_W-1:0] period_meas;
   logic             class_evt;
   logic [3:0]       class_code;
   logic [RunW-1:0]  run_eff;

   // Round the period to the nearest unit of 1<<PERIOD_SHIFT clocks, then invert the
   // player's (limit+1) table; anything off-table is reported as unknown.
   function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
      logic [QW-1:0] q;
      logic [3:0]    code;
      q = ({1'b0, p} + RoundHalf) >> PERIOD_SHIFT;
      case (q)
         QW'(31): code = 4'd0;
         QW'(33): code = 4'd1;
         QW'(35): code = 4'd2;
         QW'(37): code = 4'd3;
         QW'(39): code = 4'd4;
         QW'(41): code = 4'd5;
         QW'(43): code = 4'd6;
         QW'(46): code = 4'd7;
         QW'(49): code = 4'd8;
         QW'(52): code = 4'd9;
         QW'(54): code = 4'd10;
         default: code = NoteNone;
      endcase
      return code;
   endfunction

   always_comb begin
      xing        = sign_q & ~sample_in[WIDTH-1];
      timeout     = (counter_q == TimeoutLim);
      period_meas = counter_q + 1'b1;
      state_d     = state_q;
      counter_d   = counter_q;
      period_d    = period_q;
      class_evt   = 1'b0;
      class_code  = NoteRest;

      // A crossing always takes priority over a timeout landing in the same cycle.
      case (state_q)
         StIdle: begin
            counter_d = '0;
            if (xing) state_d = StMeasure;
         end
         StMeasure: begin
            if (xing) begin
               period_d   = period_meas;
               class_evt  = 1'b1;
               class_code = classify(period_meas);
               counter_d  = '0;
            end else if (timeout) begin
               class_evt  = 1'b1;
               class_code = NoteRest;
               counter_d  = '0;
               state_d    = StSilent;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
         StSilent: begin
            if (xing) begin
               counter_d = '0;
               state_d   = StMeasure;
            end else if (timeout) begin
               class_evt  = 1'b1;
               class_code = NoteRest;
               counter_d  = '0;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
         default: begin
            counter_d = '0;
            state_d   = StIdle;
         end
      endcase
   end

   always_comb begin
      if (class_code == cand_q) begin
         run_eff = (run_q >= RunMax) ? RunMax : run_q + 1'b1;
      end else begin
         run_eff = RunW'(1);
      end
      cand_d   = cand_q;
      run_d    = run_q;
      note_d   = note_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      if (class_evt) begin
         cand_d = class_code;
         run_d  = run_eff;
         if ((run_eff >= RunMax) && (class_code != note_q)) begin
            note_d  = class_code;
            valid_d = 1'b1;
         end
         locked_d = (class_code == note_d);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         sign_q    <= 1'b0;
         counter_q <= '0;
         period_q  <= '0;
         cand_q    <= NoteNone;
         run_q     <= '0;
         note_q    <= NoteNone;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sample_in[WIDTH-1];
         counter_q <= counter_d;
         period_q  <= period_d;
         cand_q    <= cand_d;
         run_q     <= run_d;
         note_q    <= note_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
      end
   end

   assign note_out   = note_q;
   assign note_valid = valid_q;
   assign locked     = locked_q;
   assign period_out = period_q;

endmodule
